// File: rtl/hbmc_pkg.sv
// Shared definitions for the HyperBus controller datapath blocks.
//   HBMC_WORD_W : width of one memory-side data word.
//   hbmc_lanes  : number of memory words that make up one packed word.
// The packed read-word layout {last, keep, data} depends on the instance's
// DATA_WIDTH, so each user declares it locally from its own parameters.
package hbmc_pkg;

    localparam int HBMC_WORD_W = 16;

    function automatic int hbmc_lanes(input int data_width);
        return data_width / HBMC_WORD_W;
    endfunction

endpackage

// File: rtl/hbmc_sync_fifo.sv
// Single-clock first-word-fall-through register FIFO.
//   clk, arst           : clock, asynchronous active-high reset
//   i_wdata/i_wvalid    : write side; a word is stored when i_wvalid & o_wready
//   o_wready            : space available
//   o_rdata/o_rvalid    : head word, valid whenever the FIFO is not empty
//   i_rready            : consumer takes the head word
//   o_level             : number of stored words (0..Depth)
// Depth must be a power of two so the pointers wrap on their own; fullness
// and emptiness come from the registered count.
module hbmc_sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [Width-1:0]         i_wdata,
    input  logic                     i_wvalid,
    output logic                     o_wready,
    output logic [Width-1:0]         o_rdata,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic [$clog2(Depth):0]   o_level
);

    localparam int PTR_W = $clog2(Depth);
    localparam int LVL_W = PTR_W + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_wready = (r_count != LVL_W'(Depth));
    assign o_rvalid = (r_count != '0);
    assign o_rdata  = r_mem[r_rptr];
    assign o_level  = r_count;

    assign w_push = i_wvalid & o_wready;
    assign w_pop  = o_rvalid & i_rready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            // NOTE: the storage is reset as well because the head word is read
            // straight out of it and must come up as zero, not X.
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the
            // pre-edge values of the others, regardless of statement order.
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hbmc_rd_pack.sv
// Upstream read-data packer: collects 16-bit memory read words, lane 0 first,
// into DATA_WIDTH-bit words and queues them for the AXI read-data side.
//   clk, arst            : clock, asynchronous active-high reset
//   in_data/in_last      : memory word and burst-end flag
//   in_valid/in_ready    : input handshake
//   out_data/out_keep    : packed word and lane-valid mask (bit i -> [16i+15:16i])
//   out_last             : packed word closes a burst
//   out_valid/out_ready  : output handshake (FIFO head)
//   out_level            : number of packed words stored
// A burst ending mid-word is flushed as a partial word with zeroed upper lanes.
module hbmc_rd_pack
    import hbmc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                                        clk,
    input  logic                                        arst,
    input  logic [HBMC_WORD_W-1:0]                      in_data,
    input  logic                                        in_last,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic [hbmc_lanes(DATA_WIDTH)-1:0]           out_keep,
    output logic                                        out_last,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [$clog2(DEPTH):0]                      out_level
);

    localparam int LANES  = hbmc_lanes(DATA_WIDTH);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef struct packed {
        logic                  last;
        logic [LANES-1:0]      keep;
        logic [DATA_WIDTH-1:0] data;
    } hbmc_rd_word_t;

    hbmc_rd_word_t w_push_word;
    hbmc_rd_word_t w_head_word;
    logic          w_wready;
    logic          w_accept;
    logic          w_push;

    // Acceptance depends only on the stored count: a full FIFO blocks input
    // even if the head is being popped in the same cycle.
    assign in_ready = w_wready;
    assign w_accept = in_valid & w_wready;

    if (LANES == 1) begin : g_single
        assign w_push = w_accept;

        always_comb begin
            w_push_word      = '0;
            w_push_word.data = in_data;
            w_push_word.keep = '1;
            w_push_word.last = in_last;
        end
    end else begin : g_multi
        logic [LANE_W-1:0]      r_lane;
        logic [HBMC_WORD_W-1:0] r_hold [LANES];
        logic                   w_complete;

        assign w_complete = in_last | (r_lane == LANE_W'(LANES - 1));
        assign w_push     = w_accept & w_complete;

        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                r_lane <= '0;
                for (int i = 0; i < LANES; i++) r_hold[i] <= '0;
            end else if (w_accept) begin
                if (w_complete) begin
                    r_lane <= '0;
                end else begin
                    r_hold[r_lane] <= in_data;
                    r_lane         <= r_lane + LANE_W'(1);
                end
            end
        end

        // Held lanes below the current one, the incoming word in the current
        // lane, zeros above it.
        always_comb begin
            // NOTE: default the whole word first so no path leaves a bit
            // unassigned, which would otherwise infer a latch.
            w_push_word      = '0;
            w_push_word.last = in_last;
            for (int i = 0; i < LANES; i++) begin
                if (LANE_W'(i) < r_lane) begin
                    w_push_word.data[i*HBMC_WORD_W +: HBMC_WORD_W] = r_hold[i];
                    w_push_word.keep[i] = 1'b1;
                end else if (LANE_W'(i) == r_lane) begin
                    w_push_word.data[i*HBMC_WORD_W +: HBMC_WORD_W] = in_data;
                    w_push_word.keep[i] = 1'b1;
                end
            end
        end
    end

    hbmc_sync_fifo #(
        .Width ($bits(hbmc_rd_word_t)),
        .Depth (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst     (arst),
        .i_wdata  (w_push_word),
        .i_wvalid (w_push),
        .o_wready (w_wready),
        .o_rdata  (w_head_word),
        .o_rvalid (out_valid),
        .i_rready (out_ready),
        .o_level  (out_level)
    );

    assign out_data = w_head_word.data;
    assign out_keep = w_head_word.keep;
    assign out_last = w_head_word.last;

endmodule

// File: tb/tb_hbmc_rd_pack.sv
module tb_hbmc_rd_pack;

    localparam int DW_A    = 32;
    localparam int DEPTH_A = 8;
    localparam int LANES_A = 2;
    localparam int DW_B    = 64;
    localparam int DEPTH_B = 4;

    logic clk;
    logic arst;

    logic [15:0]   a_in_data;
    logic          a_in_last, a_in_valid, a_in_ready;
    logic [31:0]   a_out_data;
    logic [1:0]    a_out_keep;
    logic          a_out_last, a_out_valid, a_out_ready;
    logic [3:0]    a_out_level;

    logic [15:0]   b_in_data;
    logic          b_in_last, b_in_valid, b_in_ready;
    logic [63:0]   b_out_data;
    logic [3:0]    b_out_keep;
    logic          b_out_last, b_out_valid, b_out_ready;
    logic [2:0]    b_out_level;

    int n_checks = 0;
    int n_fail   = 0;

    hbmc_rd_pack #(.DATA_WIDTH(DW_A), .DEPTH(DEPTH_A)) u_dut_a (
        .clk(clk), .arst(arst),
        .in_data(a_in_data), .in_last(a_in_last), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_keep(a_out_keep), .out_last(a_out_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_level(a_out_level)
    );

    hbmc_rd_pack #(.DATA_WIDTH(DW_B), .DEPTH(DEPTH_B)) u_dut_b (
        .clk(clk), .arst(arst),
        .in_data(b_in_data), .in_last(b_in_last), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_keep(b_out_keep), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_level(b_out_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of instance A: a list of words accepted into the current burst
    // segment and a queue of packed words the consumer is still owed.
    typedef struct {
        logic [63:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    logic [15:0] part[$];
    exp_t        expq[$];
    exp_t        m_w;
    bit          m_acc, m_pop;
    int          pop_count = 0;
    logic [63:0] last_pop  = '0;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            part.delete();
            expq.delete();
        end else begin
            m_acc = a_in_valid && (expq.size() < DEPTH_A);
            m_pop = a_out_ready && (expq.size() > 0);
            if (m_pop) begin
                last_pop = expq[0].data;
                pop_count++;
                void'(expq.pop_front());
            end
            if (m_acc) begin
                part.push_back(a_in_data);
                if (a_in_last || part.size() == LANES_A) begin
                    m_w.data = '0;
                    for (int k = 0; k < part.size(); k++)
                        m_w.data = m_w.data | (64'(part[k]) << (16 * k));
                    m_w.keep = 4'((1 << part.size()) - 1);
                    m_w.last = a_in_last;
                    expq.push_back(m_w);
                    part.delete();
                end
            end
        end
    end

    // Compare instance A against the model every cycle, away from the edge.
    always @(negedge clk) begin
        if (!arst) begin
            check("a_in_ready",  64'(a_in_ready),  64'(expq.size() < DEPTH_A));
            check("a_out_valid", 64'(a_out_valid), 64'(expq.size() != 0));
            check("a_out_level", 64'(a_out_level), 64'(expq.size()));
            if (expq.size() != 0) begin
                check("a_out_data", 64'(a_out_data), expq[0].data);
                check("a_out_keep", 64'(a_out_keep), 64'(expq[0].keep));
                check("a_out_last", 64'(a_out_last), 64'(expq[0].last));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [15:0] d, input logic l);
        a_in_data  = d;
        a_in_last  = l;
        a_in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (a_in_ready) break;
            if (t >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_beat_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic a_drain();
        a_out_ready = 1'b1;
        for (int t = 0; ; t++) begin
            tick(1);
            if (a_out_level == 0) break;
            if (t >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_drain_timeout: out_level=%0d, required 0", a_out_level);
                return;
            end
        end
    endtask

    task automatic b_beat(input logic [15:0] d, input logic l);
        b_in_data  = d;
        b_in_last  = l;
        b_in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (b_in_ready) break;
            if (t >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_beat_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int p0;

    initial begin
        arst        = 1'b1;
        a_in_data   = '0; a_in_last = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_data   = '0; b_in_last = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;

        // Reset state
        tick(3);
        check("rst_out_valid", 64'(a_out_valid), 64'h0);
        check("rst_out_level", 64'(a_out_level), 64'h0);
        check("rst_out_data",  64'(a_out_data),  64'h0);
        check("rst_out_keep",  64'(a_out_keep),  64'h0);
        check("rst_out_last",  64'(a_out_last),  64'h0);
        check("rst_in_ready",  64'(a_in_ready),  64'h1);
        check("rst_b_data",    b_out_data,       64'h0);
        #2 arst = 1'b0;
        tick(1);

        // Even burst
        a_out_ready = 1'b1;
        a_beat(16'h1111, 1'b0);
        a_beat(16'h2222, 1'b0);
        check("even_w0_valid", 64'(a_out_valid), 64'h1);
        check("even_w0_data",  64'(a_out_data),  64'h2222_1111);
        check("even_w0_keep",  64'(a_out_keep),  64'h3);
        check("even_w0_last",  64'(a_out_last),  64'h0);
        a_beat(16'h3333, 1'b0);
        a_beat(16'h4444, 1'b1);
        check("even_w1_data",  64'(a_out_data),  64'h4444_3333);
        check("even_w1_keep",  64'(a_out_keep),  64'h3);
        check("even_w1_last",  64'(a_out_last),  64'h1);

        // Odd burst, then a fresh burst starting at lane 0
        a_beat(16'hAAAA, 1'b0);
        a_beat(16'hBBBB, 1'b0);
        check("odd_w0_data",   64'(a_out_data),  64'hBBBB_AAAA);
        check("odd_w0_last",   64'(a_out_last),  64'h0);
        a_beat(16'hCCCC, 1'b1);
        check("odd_w1_data",   64'(a_out_data),  64'h0000_CCCC);
        check("odd_w1_keep",   64'(a_out_keep),  64'h1);
        check("odd_w1_last",   64'(a_out_last),  64'h1);
        a_beat(16'hDDDD, 1'b0);
        a_beat(16'hEEEE, 1'b1);
        check("next_w0_data",  64'(a_out_data),  64'hEEEE_DDDD);
        check("next_w0_keep",  64'(a_out_keep),  64'h3);
        a_idle();
        tick(2);

        // Full backpressure: 16 words fill 8 entries, the 17th waits
        a_out_ready = 1'b0;
        p0 = pop_count;
        for (int i = 0; i < 16; i++) a_beat(16'h0100 + 16'(i), 1'b0);
        check("full_level",    64'(a_out_level), 64'h8);
        check("full_in_ready", 64'(a_in_ready),  64'h0);
        a_in_data  = 16'h0110;
        a_in_last  = 1'b0;
        a_in_valid = 1'b1;
        tick(3);
        check("full_hold_level", 64'(a_out_level), 64'h8);
        check("full_hold_head",  64'(a_out_data),  64'h0101_0100);
        a_out_ready = 1'b1;
        for (int i = 16; i < 20; i++) a_beat(16'h0100 + 16'(i), (i == 19));
        a_idle();
        a_drain();
        check("full_pop_count", 64'(pop_count - p0), 64'd10);
        check("full_last_pop",  last_pop,            64'h0113_0112);

        // Push and pop in the same cycle at level 3
        a_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) a_beat(16'h0200 + 16'(i), (i == 5));
        a_beat(16'h0206, 1'b0);
        check("pp_level_before", 64'(a_out_level), 64'h3);
        a_in_data   = 16'h0207;
        a_in_last   = 1'b1;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        tick(1);
        a_out_ready = 1'b0;
        a_idle();
        check("pp_level_after",  64'(a_out_level), 64'h3);
        check("pp_head",         64'(a_out_data),  64'h0203_0202);
        a_drain();
        check("pp_last_pop",     last_pop,         64'h0207_0206);

        // Reset in the middle of a burst with two words stored
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) a_beat(16'h0301 + 16'(i), (i == 3));
        a_beat(16'h5555, 1'b0);
        a_idle();
        check("mr_level_before", 64'(a_out_level), 64'h2);
        #2 arst = 1'b1;
        #1;
        check("mr_valid", 64'(a_out_valid), 64'h0);
        check("mr_level", 64'(a_out_level), 64'h0);
        tick(1);
        #2 arst = 1'b0;
        tick(1);
        a_out_ready = 1'b1;
        a_beat(16'h6666, 1'b0);
        a_beat(16'h7777, 1'b1);
        check("mr_next_data", 64'(a_out_data), 64'h7777_6666);
        check("mr_next_keep", 64'(a_out_keep), 64'h3);
        a_idle();
        a_drain();

        // DATA_WIDTH = 64 instance
        b_beat(16'h1234, 1'b1);
        check("b_single_data", b_out_data,       64'h0000_0000_0000_1234);
        check("b_single_keep", 64'(b_out_keep),  64'h1);
        check("b_single_last", 64'(b_out_last),  64'h1);
        b_beat(16'h00A0, 1'b0);
        b_beat(16'h00A1, 1'b0);
        b_beat(16'h00A2, 1'b0);
        b_beat(16'h00A3, 1'b1);
        check("b_full_data",   b_out_data,       64'h00A3_00A2_00A1_00A0);
        check("b_full_keep",   64'(b_out_keep),  64'hF);
        b_beat(16'h00B0, 1'b0);
        b_beat(16'h00B1, 1'b0);
        b_beat(16'h00B2, 1'b1);
        check("b_three_data",  b_out_data,       64'h0000_00B2_00B1_00B0);
        check("b_three_keep",  64'(b_out_keep),  64'h7);
        for (int i = 0; i < 4; i++) b_beat(16'h00C0 + 16'(i), 1'b0);
        check("b_nolast_data", b_out_data,       64'h00C3_00C2_00C1_00C0);
        check("b_nolast_last", 64'(b_out_last),  64'h0);
        b_beat(16'h00C4, 1'b1);
        check("b_tail_data",   b_out_data,       64'h0000_0000_0000_00C4);
        check("b_tail_keep",   64'(b_out_keep),  64'h1);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        tick(2);
        check("b_empty_valid", 64'(b_out_valid), 64'h0);
        check("b_empty_level", 64'(b_out_level), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
